// File: rtl/snes_pad_scanner.sv
// snes_pad_scanner: scans two SNES-style pads in parallel over a shared
// latch/clock pair and publishes active-high button snapshots to mmio.
// Scans are triggered by a free-running poll timer or by poll_req.
// Optional build macro PAD_PRESENT_DETECT_EN: one extra clock pulse per scan
// samples a presence bit (0 = pad connected, 1 = open pulled-up line).
//
// state      | meaning
// S_IDLE     | waiting for a pending scan request
// S_LATCH    | pad_latch high, pads capture their button state
// S_BIT_HIGH | pad_clk high; last cycle samples bit bit_idx from both pads
// S_BIT_LOW  | pad_clk low; then next bit or finish
// S_DONE     | snapshots updated, scan_done strobe
module snes_pad_scanner #(
    parameter int CLK_DIV     = 300,
    parameter int NUM_BITS    = 16,
    parameter int POLL_PERIOD = 833333
) (
    input  logic                clock,
    input  logic                reset_btn,
    input  logic                poll_req,
    input  logic                p1_data,
    input  logic                p2_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [NUM_BITS-1:0] p1_buttons,
    output logic [NUM_BITS-1:0] p2_buttons,
    output logic                p1_present,
    output logic                p2_present,
    output logic                scan_done,
    output logic                busy
);

    localparam int HALF_W  = $clog2(2 * CLK_DIV);
    localparam int IDX_W   = $clog2(NUM_BITS + 1);
    localparam int TIMER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

`ifdef PAD_PRESENT_DETECT_EN
    localparam int SHADOW_W = NUM_BITS + 1;
`else
    localparam int SHADOW_W = NUM_BITS;
`endif

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(SHADOW_W - 1);
    localparam logic [HALF_W-1:0]  LATCH_LOAD = HALF_W'(2 * CLK_DIV - 1);
    localparam logic [HALF_W-1:0]  BIT_LOAD   = HALF_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LATCH    = 3'd1,
        S_BIT_HIGH = 3'd2,
        S_BIT_LOW  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [HALF_W-1:0]   half_cnt;
    logic                half_tc;
    logic                cnt_load;
    logic [HALF_W-1:0]   cnt_load_val;
    logic [IDX_W-1:0]    bit_idx;
    logic                idx_clr;
    logic                idx_inc;
    logic [TIMER_W-1:0]  timer;
    logic                timer_wrap;
    logic                pending;
    logic                take;
    logic                sample;
    logic                snap_load;
    logic [SHADOW_W-1:0] shadow1;
    logic [SHADOW_W-1:0] shadow2;

    assign half_tc    = (half_cnt == '0);
    assign timer_wrap = (timer == TIMER_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, pad line drive and per-state control strobes.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = BIT_LOAD;
        take         = 1'b0;
        sample       = 1'b0;
        idx_clr      = 1'b0;
        idx_inc      = 1'b0;
        snap_load    = 1'b0;
        pad_latch    = 1'b0;
        pad_clk      = 1'b1;
        busy         = 1'b0;
        scan_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    take         = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LATCH_LOAD;
                    state_next   = S_LATCH;
                end
            end
            S_LATCH: begin
                busy      = 1'b1;
                pad_latch = 1'b1;
                if (half_tc) begin
                    cnt_load   = 1'b1;
                    idx_clr    = 1'b1;
                    state_next = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                busy = 1'b1;
                if (half_tc) begin
                    sample     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                busy    = 1'b1;
                pad_clk = 1'b0;
                if (half_tc) begin
                    if (bit_idx == LAST_IDX) begin
                        snap_load  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        cnt_load   = 1'b1;
                        idx_inc    = 1'b1;
                        state_next = S_BIT_HIGH;
                    end
                end
            end
            S_DONE: begin
                scan_done  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Half-bit down-counter; a phase ends on the cycle it reads zero.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            half_cnt <= '0;
        end else if (cnt_load) begin
            half_cnt <= cnt_load_val;
        end else if (!half_tc) begin
            half_cnt <= half_cnt - HALF_W'(1);
        end
    end

    // Index of the bit currently being clocked out of the pads.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            bit_idx <= '0;
        end else if (idx_clr) begin
            bit_idx <= '0;
        end else if (idx_inc) begin
            bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    // Free-running poll timer; keeps counting through scans.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            timer <= '0;
        end else if (timer_wrap) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Request flag: timer wraps and poll_req coalesce into a single scan.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            pending <= 1'b0;
        end else begin
            pending <= poll_req | timer_wrap | (pending & ~take);
        end
    end

    // Shadow registers collect raw serial bits; bit 0 is the first bit out.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            shadow1 <= '0;
            shadow2 <= '0;
        end else if (sample) begin
            for (int k = 0; k < SHADOW_W; k++) begin
                if (bit_idx == IDX_W'(k)) begin
                    shadow1[k] <= p1_data;
                    shadow2[k] <= p2_data;
                end
            end
        end
    end

`ifdef PAD_PRESENT_DETECT_EN
    // Snapshots and presence flags update together only when a scan completes.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            p1_buttons <= '0;
            p2_buttons <= '0;
            p1_present <= 1'b1;
            p2_present <= 1'b1;
        end else if (snap_load) begin
            p1_present <= ~shadow1[NUM_BITS];
            p2_present <= ~shadow2[NUM_BITS];
            p1_buttons <= shadow1[NUM_BITS] ? '0 : ~shadow1[NUM_BITS-1:0];
            p2_buttons <= shadow2[NUM_BITS] ? '0 : ~shadow2[NUM_BITS-1:0];
        end
    end
`else
    // Snapshots update together only when a scan completes; pads assumed present.
    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            p1_buttons <= '0;
            p2_buttons <= '0;
        end else if (snap_load) begin
            p1_buttons <= ~shadow1;
            p2_buttons <= ~shadow2;
        end
    end

    assign p1_present = 1'b1;
    assign p2_present = 1'b1;
`endif

endmodule
